// File: rtl/wt_cache_pkg.sv
// Shared write-through cache types and default geometry.
// Used by wt_dcache_inval_seq (see WT_DCACHE_RESET_FLUSH_EN there).
package wt_cache_pkg;

    localparam int unsigned DCACHE_NUM_SETS  = 256;
    localparam int unsigned DCACHE_SET_ASSOC = 4;
    localparam int unsigned DCACHE_TAG_WIDTH = 44;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        INV,
        DONE
    } wt_dcache_inv_state_e;

endpackage

// File: rtl/wt_dcache_inval_seq.sv
// Flush / single-line invalidation sequencer on the dcache tag-valid port.
// Define WT_DCACHE_RESET_FLUSH_EN to sweep the tag array out of reset.
module wt_dcache_inval_seq
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumSets  = DCACHE_NUM_SETS,
    parameter int unsigned NumWays  = DCACHE_SET_ASSOC,
    parameter int unsigned TagWidth = DCACHE_TAG_WIDTH,
    localparam int unsigned IdxWidth =
        (NumSets > 1) ? $clog2(NumSets) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_req_i,
    output logic                flush_ack_o,
    input  logic                wbuffer_empty_i,
    input  logic                inv_vld_i,
    output logic                inv_rdy_o,
    input  logic [IdxWidth-1:0] inv_idx_i,
    input  logic [NumWays-1:0]  inv_way_i,
    output logic                wr_cl_vld_o,
    output logic [NumWays-1:0]  wr_cl_we_o,
    output logic [IdxWidth-1:0] wr_cl_idx_o,
    output logic [TagWidth-1:0] wr_cl_tag_o,
    output logic [NumWays-1:0]  wr_vld_bits_o,
    output logic                busy_o
);

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumSets - 1);

    wt_dcache_inv_state_e state_d, state_q;
    logic [IdxWidth-1:0]  cnt_d, cnt_q;
    logic [IdxWidth-1:0]  idx_d, idx_q;
    logic [NumWays-1:0]   way_d, way_q;

`ifdef WT_DCACHE_RESET_FLUSH_EN
    logic rst_flush_d, rst_flush_q;
`endif

    // Invalidation writes only clear valid bits; tag content is irrelevant.
    assign wr_cl_tag_o   = '0;
    assign wr_vld_bits_o = '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        way_d       = way_q;
        flush_ack_o = 1'b0;
        inv_rdy_o   = 1'b0;
        wr_cl_vld_o = 1'b0;
        wr_cl_we_o  = '0;
        wr_cl_idx_o = '0;
        busy_o      = 1'b1;
`ifdef WT_DCACHE_RESET_FLUSH_EN
        rst_flush_d = rst_flush_q;
`endif

        unique case (state_q)
            IDLE: begin
                busy_o    = 1'b0;
                inv_rdy_o = 1'b1;
                // An empty way mask completes the handshake without a write.
                if (inv_vld_i) begin
                    if (|inv_way_i) begin
                        idx_d   = inv_idx_i;
                        way_d   = inv_way_i;
                        state_d = INV;
                    end
                end else if (flush_req_i && wbuffer_empty_i) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                wr_cl_vld_o = 1'b1;
                wr_cl_we_o  = '1;
                wr_cl_idx_o = cnt_q;
                cnt_d       = cnt_q + IdxWidth'(1);
                if (cnt_q == LastIdx) begin
                    state_d = DONE;
                end
            end
            INV: begin
                wr_cl_vld_o = 1'b1;
                wr_cl_we_o  = way_q;
                wr_cl_idx_o = idx_q;
                state_d     = IDLE;
            end
            DONE: begin
`ifdef WT_DCACHE_RESET_FLUSH_EN
                flush_ack_o = ~rst_flush_q;
                rst_flush_d = 1'b0;
`else
                flush_ack_o = 1'b1;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
`ifdef WT_DCACHE_RESET_FLUSH_EN
            state_q     <= FLUSH;
            rst_flush_q <= 1'b1;
`else
            state_q     <= IDLE;
`endif
            cnt_q <= '0;
            idx_q <= '0;
            way_q <= '0;
        end else begin
`ifdef WT_DCACHE_RESET_FLUSH_EN
            rst_flush_q <= rst_flush_d;
`endif
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            way_q   <= way_d;
        end
    end

endmodule

// File: tb/tb_wt_dcache_inval_seq.sv
// Directed bench for wt_dcache_inval_seq (default geometry 256 sets x 4 ways).
// Builds with or without WT_DCACHE_RESET_FLUSH_EN.
module tb_wt_dcache_inval_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush_req = 1'b0;
    logic        flush_ack;
    logic        wb_empty = 1'b0;
    logic        inv_vld = 1'b0;
    logic        inv_rdy;
    logic [7:0]  inv_idx = '0;
    logic [3:0]  inv_way = '0;
    logic        wr_vld;
    logic [3:0]  wr_we;
    logic [7:0]  wr_idx;
    logic [43:0] wr_tag;
    logic [3:0]  wr_bits;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wt_dcache_inval_seq dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_req_i     (flush_req),
        .flush_ack_o     (flush_ack),
        .wbuffer_empty_i (wb_empty),
        .inv_vld_i       (inv_vld),
        .inv_rdy_o       (inv_rdy),
        .inv_idx_i       (inv_idx),
        .inv_way_i       (inv_way),
        .wr_cl_vld_o     (wr_vld),
        .wr_cl_we_o      (wr_we),
        .wr_cl_idx_o     (wr_idx),
        .wr_cl_tag_o     (wr_tag),
        .wr_vld_bits_o   (wr_bits),
        .busy_o          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects write idx 0 visible now; ends with idx `last` visible.
    task automatic sweep(input int last);
        for (int i = 0; i <= last; i++) begin
            chk($sformatf("flush_wr[%0d]", i),
                {wr_vld, wr_we, wr_idx, inv_rdy, flush_ack, busy},
                {1'b1, 4'hF, 8'(i), 1'b0, 1'b0, 1'b1});
            if (i < last) tick();
        end
    endtask

    task automatic finish_flush(input logic exp_ack);
        tick();
        chk("done", {flush_ack, wr_vld, wr_we, busy, inv_rdy},
            {exp_ack, 1'b0, 4'h0, 1'b1, 1'b0});
        tick();
        chk("post_done", {flush_ack, wr_vld, busy, inv_rdy},
            {1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic chk_reset(input string tag);
`ifdef WT_DCACHE_RESET_FLUSH_EN
        chk(tag, {flush_ack, inv_rdy, wr_vld, wr_we, wr_idx, busy},
            {1'b0, 1'b0, 1'b1, 4'hF, 8'h00, 1'b1});
`else
        chk(tag, {flush_ack, inv_rdy, wr_vld, wr_we, wr_idx, busy},
            {1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0});
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset("reset");
        #4 rst_n = 1'b1;
`ifdef WT_DCACHE_RESET_FLUSH_EN
        sweep(255);
        finish_flush(1'b0);
`else
        tick();
        chk_reset("idle_after_reset");
`endif

        // Flush held off while the write buffer is not drained
        flush_req = 1'b1;
        wb_empty  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("wait_wbuf", {wr_vld, busy}, 2'b00);
        end
        wb_empty = 1'b1;
        tick();
        flush_req = 1'b0;
        sweep(255);
        finish_flush(1'b1);

        // Single-line invalidation
        inv_vld = 1'b1;
        inv_idx = 8'h2A;
        inv_way = 4'b0100;
        chk("inv_rdy", {inv_rdy}, 1'b1);
        tick();
        chk("inv_wr", {wr_vld, wr_we, wr_idx, wr_bits, inv_rdy, busy},
            {1'b1, 4'b0100, 8'h2A, 4'h0, 1'b0, 1'b1});
        chk("inv_tag", {20'h0, wr_tag}, 64'h0);
        // Second request presented during INV must wait a cycle
        inv_idx = 8'h15;
        inv_way = 4'b0010;
        tick();
        chk("inv_idle", {wr_vld, busy, inv_rdy}, 3'b001);
        tick();
        inv_vld = 1'b0;
        chk("inv2_wr", {wr_vld, wr_we, wr_idx},
            {1'b1, 4'b0010, 8'h15});
        tick();
        chk("inv2_idle", {wr_vld, busy, inv_rdy}, 3'b001);

        // Empty way mask: handshake only, also blocks a same-cycle flush
        inv_vld   = 1'b1;
        inv_way   = 4'b0000;
        flush_req = 1'b1;
        chk("inv0_rdy", {inv_rdy}, 1'b1);
        tick();
        inv_vld = 1'b0;
        chk("inv0_nowr", {wr_vld, busy, inv_rdy}, 3'b001);
        tick();
        flush_req = 1'b0;
        sweep(255);
        finish_flush(1'b1);

        // Invalidation beats a simultaneous flush; reset aborts the flush
        inv_vld   = 1'b1;
        inv_idx   = 8'h33;
        inv_way   = 4'b0001;
        flush_req = 1'b1;
        tick();
        inv_vld = 1'b0;
        chk("both_inv", {wr_vld, wr_we, wr_idx},
            {1'b1, 4'b0001, 8'h33});
        tick();
        chk("both_gap", {wr_vld, busy}, 2'b00);
        tick();
        flush_req = 1'b0;
        sweep(100);
        #2 rst_n = 1'b0;
        #1 chk_reset("abort_reset");
        #2 rst_n = 1'b1;
`ifdef WT_DCACHE_RESET_FLUSH_EN
        sweep(255);
        finish_flush(1'b0);
`else
        chk_reset("abort_released");
`endif
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        sweep(255);
        finish_flush(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
